// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared types and constants for the fetch program-counter block.
//   pc_t         16-bit fetch address
//   PC_RESET     address the PC takes on reset
//   FLUSH_DEPTH  number of cycles flush stays high after a redirect
//   FCNT_W       width of the flush down-counter
//   pc_state_t   fetch-PC control states
// -----------------------------------------------------------------------------
package types_pkg;

  typedef logic [15:0] pc_t;

  localparam pc_t PC_RESET    = 16'h0000;
  localparam int  FLUSH_DEPTH = 2;
  localparam int  FCNT_W      = $clog2(FLUSH_DEPTH) + 1;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_FLUSH,
    PC_HALT
  } pc_state_t;

endpackage

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
// Program counter and fetch control. Increments the fetch address, redirects on
// taken jumps (raising flush for FLUSH_DEPTH cycles to squash wrong-path work),
// holds on hazard stalls and stops permanently on HALT until reset.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   jmp          in   taken jump/branch decision, valid every cycle
//   jmp_target   in   16-bit absolute redirect address (used when jmp=1)
//   stall        in   hazard stall, hold the PC
//   halt_req     in   HALT instruction reached decode
//   pc           out  registered fetch address
//   pc_plus1     out  combinational pc+1 (mod 2^16), link value
//   fetch_valid  out  registered, instruction at pc is fetched this cycle
//   flush        out  registered, squash younger in-flight instructions
//   halted       out  registered, core stopped
// -----------------------------------------------------------------------------
module fetch_pc
  import types_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jmp,
  input  logic [15:0] jmp_target,
  input  logic        stall,
  input  logic        halt_req,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted
);

  pc_state_t           state_q, state_d;
  pc_t                 pc_q, pc_d;
  logic                valid_q, valid_d;
  logic                flush_q, flush_d;
  logic                halted_q, halted_d;
  logic [FCNT_W-1:0]   cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PC_RUN;
      pc_q     <= PC_RESET;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default (hold) first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    flush_d  = flush_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      PC_RUN: begin
        if (!valid_q) begin
          // First edge out of reset: fetch the reset address, do not advance.
          valid_d = 1'b1;
        end else if (jmp) begin
          pc_d    = jmp_target;
          flush_d = 1'b1;
          cnt_d   = FCNT_W'(FLUSH_DEPTH - 1);
          state_d = PC_FLUSH;
        end else if (halt_req) begin
          // Halt wins over stall; the PC freezes on the halting address.
          state_d  = PC_HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else if (!stall) begin
          pc_d = pc_q + 16'd1;
        end
      end

      PC_FLUSH: begin
        // halt_req is a wrong-path instruction here and is ignored.
        if (jmp) begin
          pc_d    = jmp_target;
          flush_d = 1'b1;
          cnt_d   = FCNT_W'(FLUSH_DEPTH - 1);
        end else if (!stall) begin
          pc_d = pc_q + 16'd1;
          // Counter holds the remaining flush cycles after this one; a stall
          // freezes the window along with the PC.
          if (cnt_q == '0) begin
            flush_d = 1'b0;
            state_d = PC_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      PC_HALT: begin
        // Terminal until reset.
      end

      default: begin
        state_d = PC_RUN;
      end
    endcase
  end

  assign pc          = pc_q;
  assign pc_plus1    = pc_q + 16'd1;
  assign fetch_valid = valid_q;
  assign flush       = flush_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_pc.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc
// Self-checking bench for fetch_pc: directed stimulus, a behavioural model
// compared on every falling edge, and literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_fetch_pc;
  import types_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        stall;
  logic        halt_req;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        fetch_valid;
  logic        flush;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  fetch_pc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .stall       (stall),
    .halt_req    (halt_req),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a fetch address, whether fetching has started, whether
  // the core has stopped, and how many flush cycles remain to be shown.
  // ---------------------------------------------------------------------------
  pc_t m_pc     = PC_RESET;
  bit  m_valid  = 1'b0;
  bit  m_halted = 1'b0;
  int  m_left   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = PC_RESET; m_valid = 1'b0; m_halted = 1'b0; m_left = 0;
    end else if (m_halted) begin
      // stopped until reset
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (jmp) begin
      m_pc   = jmp_target;
      m_left = FLUSH_DEPTH;
    end else if (halt_req && m_left == 0) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (!stall) begin
      m_pc = m_pc + 16'd1;
      if (m_left > 0) m_left--;
    end
  end

  always @(negedge clk) begin
    pc_t exp_p1;
    exp_p1 = m_pc + 16'd1;
    check("model_pc",       pc,          m_pc);
    check("model_pc_plus1", pc_plus1,    exp_p1);
    check("model_valid",    fetch_valid, m_valid);
    check("model_flush",    flush,       m_left > 0);
    check("model_halted",   halted,      m_halted);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input logic j, input pc_t t, input logic s, input logic h);
    jmp = j; jmp_target = t; stall = s; halt_req = h;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input pc_t p, input logic v,
                            input logic f, input logic h);
    check({tag, "_pc"},     pc,          p);
    check({tag, "_valid"},  fetch_valid, v);
    check({tag, "_flush"},  flush,       f);
    check({tag, "_halted"}, halted,      h);
  endtask

  initial begin
    rst_n = 1'b0; jmp = 1'b0; jmp_target = 16'h0000; stall = 1'b0; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Reset release and idle: pc 0,0,1,2,3
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("idle0", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("idle1", 16'h0001, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("idle2", 16'h0002, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("idle3", 16'h0003, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("at5", 16'h0005, 1'b1, 1'b0, 1'b0);

    // Jump from 0x0005 to 0x0040: flush for two cycles
    step(1'b1, 16'h0040, 1'b0, 1'b0); expect_out("jmp0", 16'h0040, 1'b1, 1'b1, 1'b0);
    check("jmp0_plus1", pc_plus1, 16'h0041);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("jmp1", 16'h0041, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("jmp2", 16'h0042, 1'b1, 1'b0, 1'b0);

    // Stall together with jump: jump wins; then stall alone freezes pc
    step(1'b1, 16'h0100, 1'b1, 1'b0); expect_out("sjmp", 16'h0100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0); expect_out("stall", 16'h0100, 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("unst0", 16'h0101, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("unst1", 16'h0102, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0); expect_out("runstall", 16'h0102, 1'b1, 1'b0, 1'b0);

    // Re-jump inside a flush window restarts it
    step(1'b1, 16'h0180, 1'b0, 1'b0); expect_out("rj0", 16'h0180, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h01C0, 1'b0, 1'b0); expect_out("rj1", 16'h01C0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("rj2", 16'h01C1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("rj3", 16'h01C2, 1'b1, 1'b0, 1'b0);

    // halt_req during flush is ignored, then taken in PC_RUN
    step(1'b1, 16'h0200, 1'b0, 1'b0); expect_out("hf0", 16'h0200, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1); expect_out("hf1", 16'h0201, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1); expect_out("hf2", 16'h0202, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b1); expect_out("halt", 16'h0202, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0300, 1'b0, 1'b0); expect_out("hjmp", 16'h0202, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1); expect_out("hidle", 16'h0202, 1'b0, 1'b0, 1'b1);

    // Reset out of halt
    rst_n = 1'b0;
    #1;
    expect_out("hrst", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("rel2", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Wrap at 0xFFFF
    step(1'b1, 16'hFFFE, 1'b0, 1'b0); expect_out("w0", 16'hFFFE, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("w1", 16'hFFFF, 1'b1, 1'b1, 1'b0);
    check("w1_plus1", pc_plus1, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("w2", 16'h0000, 1'b1, 1'b0, 1'b0);
    check("w2_plus1", pc_plus1, 16'h0001);

    // Asynchronous reset in the middle of a flush window
    step(1'b1, 16'h0300, 1'b0, 1'b0); expect_out("af0", 16'h0300, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_out("arst", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("arel", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0); expect_out("arel1", 16'h0001, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
